// File: rtl/bar_run_scan.sv
// bar_run_scan: run-length encodes bar/space pixels on evenly spaced rows between each row's first and last bar.
// Runs are queued in a show-ahead FIFO. Frame detect/extent is reported. Build option: BAR_SCAN_MAJ3_EN (majority filter).
module bar_run_scan #(
    parameter int H_BITS     = 10,
    parameter int V_BITS     = 10,
    parameter int V_START    = 100,
    parameter int V_STEP     = 20,
    parameter int SCAN_LINES = 4,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int MIN_RUNS   = 59
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [H_BITS-1:0] loc_x,
    input  logic [V_BITS-1:0] loc_y,
    input  logic              thres_vs,
    input  logic              thres_de,
    input  logic              thres_data,
    output logic              run_valid,
    input  logic              run_ready,
    output logic [LEN_W-1:0]  run_len,
    output logic              run_level,
    output logic              run_last,
    output logic [3:0]        run_line,
    output logic              scan_en,
    output logic [H_BITS-1:0] bar_left,
    output logic [H_BITS-1:0] bar_right,
    output logic              overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = LEN_W + 6;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_QUIET, S_RUN, S_FLUSH} state_t;

    // ---------------- input registers ----------------
    logic [H_BITS-1:0] x_q;
    logic [V_BITS-1:0] y_q;
    logic              vs_q, de_q, data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            data_q <= 1'b0;
        end else begin
            x_q    <= loc_x;
            y_q    <= loc_y;
            vs_q   <= thres_vs;
            de_q   <= thres_de;
            data_q <= thres_data;
        end
    end

    // ---------------- pixel stage seen by the row FSM ----------------
    logic [H_BITS-1:0] px_x;
    logic [V_BITS-1:0] px_y;
    logic              px_vs, px_de, px_data;

`ifdef BAR_SCAN_MAJ3_EN
    logic [H_BITS-1:0] x1_q;
    logic [V_BITS-1:0] y1_q;
    logic              vs1_q, de1_q, data1_q, de2_q, data2_q;
    logic              prev_px, next_px;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q    <= '0;
            y1_q    <= '0;
            vs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            data1_q <= 1'b0;
            de2_q   <= 1'b0;
            data2_q <= 1'b0;
        end else begin
            x1_q    <= x_q;
            y1_q    <= y_q;
            vs1_q   <= vs_q;
            de1_q   <= de_q;
            data1_q <= data_q;
            de2_q   <= de1_q;
            data2_q <= data1_q;
        end
    end

    // Neighbours outside the active line are replaced by the centre pixel (edge replication).
    always_comb begin
        prev_px = de2_q ? data2_q : data1_q;
        next_px = de_q ? data_q : data1_q;
    end

    // The centre tap keeps its own column, so x needs no further correction.
    assign px_x    = x1_q;
    assign px_y    = y1_q;
    assign px_vs   = vs1_q;
    assign px_de   = de1_q;
    assign px_data = de1_q & ((prev_px & data1_q) | (prev_px & next_px) | (data1_q & next_px));
`else
    assign px_x    = x_q;
    assign px_y    = y_q;
    assign px_vs   = vs_q;
    assign px_de   = de_q;
    assign px_data = data_q;
`endif

    logic de_prev_q, vs_prev_q;
    logic de_rise, vs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            de_prev_q <= px_de;
            vs_prev_q <= px_vs;
        end
    end

    assign de_rise = px_de & ~de_prev_q;
    assign vs_rise = px_vs & ~vs_prev_q;

    // ---------------- scanned-row decode ----------------
    logic [SCAN_LINES-1:0] row_hit;
    logic [3:0]            row_idx;
    logic                  row_sel;

    generate
        for (genvar gi = 0; gi < SCAN_LINES; gi++) begin : g_row
            assign row_hit[gi] = (px_y == V_BITS'(V_START + gi * V_STEP));
        end
    endgenerate

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < SCAN_LINES; i++) begin
            if (row_hit[i]) row_idx = 4'(i);
        end
    end

    assign row_sel = |row_hit;

    // ---------------- row FSM ----------------
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              level_q, level_d;
    logic              hold_valid_q, hold_valid_d;
    logic [LEN_W-1:0]  hold_len_q, hold_len_d;
    logic              hold_level_q, hold_level_d;
    logic [3:0]        line_q, line_d;
    logic [H_BITS-1:0] first_x_q, first_x_d;
    logic [H_BITS-1:0] last_x_q, last_x_d;
    logic [7:0]        run_cnt_q, run_cnt_d;
    logic              push_valid_q, push_valid_d;
    logic [LEN_W-1:0]  push_len_q, push_len_d;
    logic              push_level_q, push_level_d;
    logic              push_last_q, push_last_d;
    logic [3:0]        push_line_q, push_line_d;
    logic              armed_q, armed_d;
    logic              row_start, open_bar;

    assign row_start = (state_q == S_IDLE) && armed_q && de_rise && row_sel;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        level_d      = level_q;
        hold_valid_d = hold_valid_q;
        hold_len_d   = hold_len_q;
        hold_level_d = hold_level_q;
        line_d       = line_q;
        first_x_d    = first_x_q;
        last_x_d     = last_x_q;
        run_cnt_d    = run_cnt_q;
        push_valid_d = 1'b0;
        push_len_d   = hold_len_q;
        push_level_d = hold_level_q;
        push_last_d  = 1'b0;
        push_line_d  = line_q;
        open_bar     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (row_start) begin
                    line_d       = row_idx;
                    run_cnt_d    = '0;
                    hold_valid_d = 1'b0;
                    state_d      = S_QUIET;
                    open_bar     = px_data;
                end
            end
            S_QUIET: begin
                if (!px_de) state_d = S_IDLE;
                else        open_bar = px_data;
            end
            S_RUN: begin
                if (!px_de) begin
                    // A trailing space run is simply dropped; a trailing bar becomes the held run.
                    if (level_q) begin
                        push_valid_d = hold_valid_q;
                        hold_valid_d = 1'b1;
                        hold_len_d   = len_q;
                        hold_level_d = 1'b1;
                    end
                    state_d = S_FLUSH;
                end else if (px_data == level_q) begin
                    if (len_q != LEN_MAX) len_d = len_q + LEN_ONE;
                    if (px_data) last_x_d = px_x;
                end else begin
                    push_valid_d = hold_valid_q;
                    hold_valid_d = 1'b1;
                    hold_len_d   = len_q;
                    hold_level_d = level_q;
                    len_d        = LEN_ONE;
                    level_d      = px_data;
                    if (px_data) last_x_d = px_x;
                end
            end
            S_FLUSH: begin
                push_valid_d = hold_valid_q;
                push_last_d  = 1'b1;
                hold_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (open_bar) begin
            state_d   = S_RUN;
            len_d     = LEN_ONE;
            level_d   = 1'b1;
            first_x_d = px_x;
            last_x_d  = px_x;
        end

        if (push_valid_d && (run_cnt_q != 8'hFF)) run_cnt_d = run_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            level_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_len_q   <= '0;
            hold_level_q <= 1'b0;
            line_q       <= '0;
            first_x_q    <= '0;
            last_x_q     <= '0;
            run_cnt_q    <= '0;
            push_valid_q <= 1'b0;
            push_len_q   <= '0;
            push_level_q <= 1'b0;
            push_last_q  <= 1'b0;
            push_line_q  <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            level_q      <= level_d;
            hold_valid_q <= hold_valid_d;
            hold_len_q   <= hold_len_d;
            hold_level_q <= hold_level_d;
            line_q       <= line_d;
            first_x_q    <= first_x_d;
            last_x_q     <= last_x_d;
            run_cnt_q    <= run_cnt_d;
            push_valid_q <= push_valid_d;
            push_len_q   <= push_len_d;
            push_level_q <= push_level_d;
            push_last_q  <= push_last_d;
            push_line_q  <= push_line_d;
        end
    end

    // ---------------- run FIFO (show-ahead) ----------------
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] head;
    logic             wr_en, drop, pop;

    // A full FIFO drops the push even when a pop frees a slot in the same cycle.
    assign wr_en = push_valid_q && (count_q != CNT_FULL);
    assign drop  = push_valid_q && (count_q == CNT_FULL);
    assign pop   = (count_q != '0) && run_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {push_len_q, push_level_q, push_last_q, push_line_q};
    end

    assign head      = mem[rd_ptr_q];
    assign run_valid = (count_q != '0);
    assign run_len   = run_valid ? head[ENT_W-1 -: LEN_W] : '0;
    assign run_level = run_valid & head[5];
    assign run_last  = run_valid & head[4];
    assign run_line  = run_valid ? head[3:0] : 4'd0;

    // ---------------- frame accumulation ----------------
    logic              row_bad_q, row_bad_d;
    logic              overflow_q, overflow_d;
    logic              scan_en_q, scan_en_d;
    logic [H_BITS-1:0] bar_left_q, bar_left_d, bar_right_q, bar_right_d;
    logic              acc_any_q, acc_any_d;
    logic [H_BITS-1:0] acc_left_q, acc_left_d, acc_right_q, acc_right_d;
    logic              row_end, row_ok;

    // The last push of a row is judged at the write stage so that its own drop still marks the row bad.
    assign row_end = push_valid_q && push_last_q;
    assign row_ok  = !(row_bad_q || drop) && (int'(run_cnt_q) >= MIN_RUNS);

    always_comb begin
        armed_d     = armed_q;
        row_bad_d   = row_bad_q;
        overflow_d  = overflow_q;
        scan_en_d   = scan_en_q;
        bar_left_d  = bar_left_q;
        bar_right_d = bar_right_q;
        acc_any_d   = acc_any_q;
        acc_left_d  = acc_left_q;
        acc_right_d = acc_right_q;

        if (row_start) row_bad_d = 1'b0;
        if (drop) begin
            row_bad_d  = 1'b1;
            overflow_d = 1'b1;
        end
        if (row_end && row_ok) begin
            acc_any_d   = 1'b1;
            acc_left_d  = (!acc_any_q || first_x_q < acc_left_q) ? first_x_q : acc_left_q;
            acc_right_d = (!acc_any_q || last_x_q > acc_right_q) ? last_x_q : acc_right_q;
        end
        if (vs_rise) begin
            armed_d   = 1'b1;
            scan_en_d = acc_any_q;
            if (acc_any_q) begin
                bar_left_d  = acc_left_q;
                bar_right_d = acc_right_q;
            end
            acc_any_d   = 1'b0;
            acc_left_d  = '0;
            acc_right_d = '0;
            overflow_d  = drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            row_bad_q   <= 1'b0;
            overflow_q  <= 1'b0;
            scan_en_q   <= 1'b0;
            bar_left_q  <= '0;
            bar_right_q <= '0;
            acc_any_q   <= 1'b0;
            acc_left_q  <= '0;
            acc_right_q <= '0;
        end else begin
            armed_q     <= armed_d;
            row_bad_q   <= row_bad_d;
            overflow_q  <= overflow_d;
            scan_en_q   <= scan_en_d;
            bar_left_q  <= bar_left_d;
            bar_right_q <= bar_right_d;
            acc_any_q   <= acc_any_d;
            acc_left_q  <= acc_left_d;
            acc_right_q <= acc_right_d;
        end
    end

    assign scan_en   = scan_en_q;
    assign bar_left  = bar_left_q;
    assign bar_right = bar_right_q;
    assign overflow  = overflow_q;

endmodule
